display_source_ctrl: RTL and testbench

- Upstream stage of Display4Driver. Selects what the 4-digit display shows: live temperature, setpoint, or setpoint under edit.
- Produces the driver's 16-bit binary value (inputNum), its active-high blank (en: 1 = all digits off) and its divided scan clock.
- Accepts temperature samples over a valid/ready handshake, clamps values to 4 decimal digits, blinks during edit, blanks on stale data and times out back to temperature view.

---
 rtl/display_source_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_display_source_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_source_ctrl.sv
// -----------------------------------------------------------------------------
// display_source_ctrl
//
// Upstream stage of Display4Driver. It picks what the 4-digit display shows:
// the live temperature, the setpoint, or the setpoint while it is being edited.
// Temperature samples arrive over a valid/ready handshake. Displayed values are
// clamped to MAX_VAL. The edit view blinks. The temperature view goes dark when
// no sample has arrived for STALE_TICKS cycles. The setpoint views fall back to
// the temperature view after TIMEOUT_TICKS idle cycles.
//
// Ports:
//   clk         system clock (only clock)
//   rst         synchronous, active-high reset
//   temp_valid  temperature sample valid
//   temp_data   unsigned temperature sample, tenths of a degree
//   temp_ready  block can accept a sample
//   setpoint    current setpoint, sampled live every cycle
//   btn_mode    single-cycle pulse: SHOW_TEMP -> SHOW_SET -> EDIT_SET -> SHOW_TEMP
//   btn_adjust  single-cycle pulse: restarts the timeout and the blink phase
//   disp_num    binary value to Display4Driver inputNum (always <= MAX_VAL)
//   disp_blank  to Display4Driver en, 1 = display dark
//   scan_clk    divided scan clock, period 2*SCAN_DIV clk cycles
//   edit_mode   1 while in EDIT_SET
//
// Optional feature macro: DISP_LAMP_TEST_EN
//   When defined, the block runs a lamp test after reset. For 2*BLINK_TICKS
//   cycles it shows 8888 unblanked and ignores btn_mode. Samples are still
//   accepted during the lamp test.
// -----------------------------------------------------------------------------
module display_source_ctrl #(
   parameter int unsigned SCAN_DIV      = 25000,
   parameter int unsigned BLINK_TICKS   = 12500000,
   parameter int unsigned TIMEOUT_TICKS = 250000000,
   parameter int unsigned STALE_TICKS   = 100000000,
   parameter logic [15:0] MAX_VAL       = 16'd9999
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        temp_valid,
   input  logic [15:0] temp_data,
   output logic        temp_ready,
   input  logic [15:0] setpoint,
   input  logic        btn_mode,
   input  logic        btn_adjust,
   output logic [15:0] disp_num,
   output logic        disp_blank,
   output logic        scan_clk,
   output logic        edit_mode
);

   localparam logic [1:0]  SHOW_TEMP = 2'd0;
   localparam logic [1:0]  SHOW_SET  = 2'd1;
   localparam logic [1:0]  EDIT_SET  = 2'd2;
   localparam logic [15:0] LAMP_VAL  = 16'd8888;

   function automatic logic [15:0] sat_val(input logic [15:0] v);
      return (v > MAX_VAL) ? MAX_VAL : v;
   endfunction

   logic [1:0]  state;
   logic [1:0]  next_state;
   logic [15:0] temp_reg;
   logic        stale_flag;
   logic [31:0] stale_cnt;
   logic [31:0] to_cnt;
   logic [31:0] blink_cnt;
   logic        blink_phase;
   logic [31:0] scan_cnt;
   logic        scan_q;
   logic        acc_p0;
   logic        accept;
   logic        lamp_active;
   logic [15:0] disp_num_p1;
   logic        disp_blank_p1;
   logic        edit_mode_p1;

   // Ready drops for one cycle after every accept. Ready is also low while rst
   // is asserted, so a sample offered during reset is dropped.
   assign temp_ready = ~rst & ~acc_p0;
   assign accept     = temp_valid & temp_ready;

`ifdef DISP_LAMP_TEST_EN
   logic [31:0] lamp_cnt;
   logic        lamp_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         lamp_q   <= 1'b1;
         lamp_cnt <= '0;
      end else if (lamp_q) begin
         if (lamp_cnt == 2 * BLINK_TICKS - 1) begin
            lamp_q   <= 1'b0;
            lamp_cnt <= '0;
         end else begin
            lamp_cnt <= lamp_cnt + 32'd1;
         end
      end
   end

   assign lamp_active = lamp_q;
`else
   assign lamp_active = 1'b0;
`endif

   // A btn_mode press beats a timeout that expires in the same cycle.
   always_comb begin
      next_state = state;
      if (!lamp_active) begin
         if (btn_mode) begin
            case (state)
               SHOW_TEMP: next_state = SHOW_SET;
               SHOW_SET:  next_state = EDIT_SET;
               default:   next_state = SHOW_TEMP;
            endcase
         end else if (state != SHOW_TEMP && to_cnt == TIMEOUT_TICKS - 1) begin
            next_state = SHOW_TEMP;
         end
      end
   end

   // Stage p0: handshake, stale tracking, FSM, timers
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_p0     <= 1'b0;
         temp_reg   <= '0;
         stale_flag <= 1'b1;
         stale_cnt  <= '0;
         state      <= SHOW_TEMP;
         to_cnt     <= '0;
         blink_cnt  <= '0;
         blink_phase <= 1'b0;
         scan_cnt   <= '0;
         scan_q     <= 1'b0;
      end else begin
         acc_p0 <= accept;

         // The stale counter holds at its terminal count.
         if (accept) begin
            temp_reg   <= sat_val(temp_data);
            stale_flag <= 1'b0;
            stale_cnt  <= '0;
         end else if (stale_cnt == STALE_TICKS - 1) begin
            stale_flag <= 1'b1;
         end else begin
            stale_cnt <= stale_cnt + 32'd1;
         end

         state <= next_state;

         if (btn_mode || btn_adjust || next_state != state || state == SHOW_TEMP)
            to_cnt <= '0;
         else
            to_cnt <= to_cnt + 32'd1;

         // The blink phase restarts visible on entry to EDIT_SET and on every
         // adjust, so the value does not vanish while it is being changed.
         if (state != EDIT_SET || btn_adjust) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
         end else if (blink_cnt == BLINK_TICKS - 1) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 32'd1;
         end

         if (scan_cnt == SCAN_DIV - 1) begin
            scan_cnt <= '0;
            scan_q   <= ~scan_q;
         end else begin
            scan_cnt <= scan_cnt + 32'd1;
         end
      end
   end

   // Stage p1: registered output selection
   always_ff @(posedge clk) begin
      if (rst) begin
         disp_num_p1   <= '0;
         disp_blank_p1 <= 1'b1;
         edit_mode_p1  <= 1'b0;
      end else begin
         edit_mode_p1 <= (state == EDIT_SET);
         if (lamp_active) begin
            disp_num_p1   <= LAMP_VAL;
            disp_blank_p1 <= 1'b0;
         end else begin
            case (state)
               SHOW_TEMP: begin
                  disp_num_p1   <= temp_reg;
                  disp_blank_p1 <= stale_flag;
               end
               SHOW_SET: begin
                  disp_num_p1   <= sat_val(setpoint);
                  disp_blank_p1 <= 1'b0;
               end
               default: begin
                  disp_num_p1   <= sat_val(setpoint);
                  disp_blank_p1 <= blink_phase;
               end
            endcase
         end
      end
   end

   assign disp_num   = disp_num_p1;
   assign disp_blank = disp_blank_p1;
   assign edit_mode  = edit_mode_p1;
   assign scan_clk   = scan_q;

endmodule

// File: tb/tb_display_source_ctrl.sv
module tb_display_source_ctrl;

   logic        clk;
   logic        rst;
   logic        temp_valid;
   logic [15:0] temp_data;
   logic        temp_ready;
   logic [15:0] setpoint;
   logic        btn_mode;
   logic        btn_adjust;
   logic [15:0] disp_num;
   logic        disp_blank;
   logic        scan_clk;
   logic        edit_mode;

   int tests;
   int fails;
   logic [15:0] pat;

   display_source_ctrl #(
      .SCAN_DIV      (2),
      .BLINK_TICKS   (4),
      .TIMEOUT_TICKS (20),
      .STALE_TICKS   (10),
      .MAX_VAL       (16'd9999)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .temp_valid (temp_valid),
      .temp_data  (temp_data),
      .temp_ready (temp_ready),
      .setpoint   (setpoint),
      .btn_mode   (btn_mode),
      .btn_adjust (btn_adjust),
      .disp_num   (disp_num),
      .disp_blank (disp_blank),
      .scan_clk   (scan_clk),
      .edit_mode  (edit_mode)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [15:0] v);
      temp_valid = 1'b1;
      temp_data  = v;
      tick(1);
      temp_valid = 1'b0;
   endtask

   initial begin
      tests      = 0;
      fails      = 0;
      rst        = 1'b1;
      temp_valid = 1'b0;
      temp_data  = '0;
      setpoint   = '0;
      btn_mode   = 1'b0;
      btn_adjust = 1'b0;
      pat        = 16'b0000111100001111;

      // reset state
      tick(3);
      chk1 ("rst_blank", disp_blank, 1'b1);
      chk16("rst_num",   disp_num,   16'd0);
      chk1 ("rst_ready", temp_ready, 1'b0);
      chk1 ("rst_edit",  edit_mode,  1'b0);
      chk1 ("rst_scan",  scan_clk,   1'b0);

      rst = 1'b0;
      #1;
      chk1("ready_after_rst", temp_ready, 1'b1);

      // scan clock: toggles every 2 cycles
      tick(1);
      chk1("scan_r1", scan_clk, 1'b0);
`ifdef DISP_LAMP_TEST_EN
      chk16("lamp_num_r1",   disp_num,   16'd8888);
      chk1 ("lamp_blank_r1", disp_blank, 1'b0);
`else
      chk16("temp_num_r1",   disp_num,   16'd0);
      chk1 ("temp_blank_r1", disp_blank, 1'b1);
`endif
      tick(1);
      chk1("scan_r2", scan_clk, 1'b1);
      tick(1);
      chk1("scan_r3", scan_clk, 1'b1);
      tick(1);
      chk1("scan_r4", scan_clk, 1'b0);

`ifdef DISP_LAMP_TEST_EN
      btn_mode = 1'b1;
      tick(1);
      btn_mode = 1'b0;
      tick(3);
      chk16("lamp_num_r8",   disp_num,   16'd8888);
      chk1 ("lamp_blank_r8", disp_blank, 1'b0);
      tick(1);
      chk16("post_lamp_num",   disp_num,   16'd0);
      chk1 ("post_lamp_blank", disp_blank, 1'b1);
      chk1 ("post_lamp_edit",  edit_mode,  1'b0);
      tick(1);
      chk1 ("lamp_btn_ignored", disp_blank, 1'b1);
`endif

      // first sample
      send(16'd253);
      chk1("ready_low_after_accept", temp_ready, 1'b0);
      tick(1);
      chk1 ("ready_back", temp_ready, 1'b1);
      chk16("num_253",    disp_num,   16'd253);
      chk1 ("blank_fresh", disp_blank, 1'b0);

      // saturation boundaries
      send(16'd12000);
      tick(1);
      chk16("sat_12000", disp_num, 16'd9999);
      send(16'd9998);
      tick(1);
      chk16("pass_9998", disp_num, 16'd9998);
      send(16'd10000);
      tick(1);
      chk16("sat_10000", disp_num, 16'd9999);
      send(16'd65535);
      tick(1);
      chk16("sat_65535", disp_num, 16'd9999);

      // stale: flag set at 10th edge after accept, visible one edge later
      tick(9);
      chk1("stale_not_yet", disp_blank, 1'b0);
      tick(1);
      chk1("stale_blank", disp_blank, 1'b1);

      send(16'd300);
      tick(1);
      chk16("num_300",     disp_num,   16'd300);
      chk1 ("unstale_300", disp_blank, 1'b0);

      // SHOW_SET
      setpoint = 16'd450;
      btn_mode = 1'b1;
      tick(1);
      btn_mode = 1'b0;
      tick(1);
      chk16("set_num",   disp_num,   16'd450);
      chk1 ("set_blank", disp_blank, 1'b0);
      chk1 ("set_edit",  edit_mode,  1'b0);

      // EDIT_SET blink pattern
      btn_mode = 1'b1;
      tick(1);
      btn_mode = 1'b0;
      for (int k = 0; k < 16; k++) begin
         tick(1);
         chk1("edit_blink", disp_blank, pat[15-k]);
         chk1("edit_mode_on", edit_mode, 1'b1);
      end
      chk16("edit_num", disp_num, 16'd450);

      // adjust restarts the blink count and the timeout
      tick(2);
      btn_adjust = 1'b1;
      tick(1);
      btn_adjust = 1'b0;
      tick(1);
      chk1("adj_blank_e20", disp_blank, 1'b0);
      tick(1);
      chk1("adj_blank_e21", disp_blank, 1'b0);
      chk1("adj_no_timeout", edit_mode, 1'b1);
      tick(2);
      chk1("adj_blank_e23", disp_blank, 1'b0);
      tick(1);
      chk1("adj_blank_e24", disp_blank, 1'b1);
      btn_adjust = 1'b1;
      tick(1);
      btn_adjust = 1'b0;
      chk1("adj2_blank_lag", disp_blank, 1'b1);
      tick(1);
      chk1("adj2_visible", disp_blank, 1'b0);

      // timeout: 20 idle cycles after the last adjust
      tick(19);
      chk1("timeout_edge_edit", edit_mode, 1'b1);
      tick(1);
      chk1 ("timeout_edit_off", edit_mode,  1'b0);
      chk16("timeout_temp_num", disp_num,   16'd300);
      chk1 ("timeout_stale",    disp_blank, 1'b1);

      // btn_mode on the timeout cycle in SHOW_SET wins
      btn_mode = 1'b1;
      tick(1);
      btn_mode = 1'b0;
      setpoint = 16'd12345;
      tick(1);
      chk16("set_sat", disp_num, 16'd9999);
      tick(18);
      btn_mode = 1'b1;
      tick(1);
      btn_mode = 1'b0;
      tick(1);
      chk1("btn_beats_timeout", edit_mode, 1'b1);
      tick(19);
      chk1("to_cleared_edge", edit_mode, 1'b1);
      tick(1);
      chk1("to_cleared_exit", edit_mode, 1'b0);

      // reset mid-edit with a sample pending
      btn_mode = 1'b1;
      tick(2);
      btn_mode = 1'b0;
      tick(1);
      chk1("pre_rst_edit", edit_mode, 1'b1);
      rst        = 1'b1;
      temp_valid = 1'b1;
      temp_data  = 16'd777;
      #1;
      chk1("rst_ready_comb", temp_ready, 1'b0);
      tick(1);
      chk1 ("midrst_edit",  edit_mode,  1'b0);
      chk1 ("midrst_blank", disp_blank, 1'b1);
      chk16("midrst_num",   disp_num,   16'd0);
      rst        = 1'b0;
      temp_valid = 1'b0;
      tick(1);
      chk1("post_rst_edit", edit_mode, 1'b0);
`ifndef DISP_LAMP_TEST_EN
      chk16("dropped_sample", disp_num,   16'd0);
      chk1 ("post_rst_blank", disp_blank, 1'b1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
